word_mem: RTL and testbench
===========================

Name: word_mem

Overview:
- Word-organised scratch memory serving the rotate-and-writeback sequencer.
- The sequencer presents a byte address and reads the word combinationally. It then writes a transformed word back with a one-cycle write strobe.
- Adds tracking of accepted writes, a running XOR checksum of contents, and sticky address-error capture.
- Used as the sequencer's memory and as the observation point for the bench.

Parameters:
- DEPTH, 4, number of 32-bit words; power of two, 2..1024.
- INIT_BASE, 32'h0000_0001, seed for reset contents; word i resets to INIT_BASE rotated left by i bits.

Ports:
- clk  input  1  clock, all state updates on rising edge
- nrst  input  1  asynchronous active-low reset
- wr_en  input  1  write strobe, sampled at rising edge
- lock  input  1  write inhibit; when 1, writes are ignored
- addr  input  32  byte address, shared by read and write
- data_in  input  32  write data
- data_out  output  32  combinational read data
- wr_count  output  16  number of accepted writes, saturating
- checksum  output  32  XOR of all DEPTH words, registered
- err  output  1  sticky flag for an invalid-address write attempt
- err_addr  output  32  address of the first invalid write attempt

Behaviour:
- Address validity:
  - addr is valid iff addr[1:0]==0 and addr[31:2] < DEPTH.
  - Word index = addr[1+log2(DEPTH):2].
- Reset (nrst low, asynchronous, any time including mid-write):
  - mem[i] = rotl(INIT_BASE, i).
  - wr_count = 0; err = 0; err_addr = 0.
  - checksum = XOR over i of rotl(INIT_BASE, i).
  - Reset dominates all other inputs.
- Read path:
  - data_out = mem[index] when addr is valid, else 32'h0.
  - Purely combinational, zero latency.
  - Reads are never flagged as errors.
- Write acceptance: wr_en=1, lock=0 and addr valid at the rising edge.
  - mem[index] <= data_in.
  - checksum <= checksum ^ mem[index] ^ data_in (old value of the word).
  - wr_count <= wr_count + 1, holding at 16'hFFFF once reached.
- Read-during-write:
  - In the cycle wr_en is high, data_out shows the old word.
  - The new word is visible after the edge.
  - Writing the same value twice leaves checksum unchanged.
- Invalid write: wr_en=1, lock=0 and addr invalid.
  - Memory, checksum and wr_count are unchanged.
  - err <= 1.
  - err_addr <= addr only if err was 0 before the edge; the first error is held.
- Locked write: wr_en=1 with lock=1.
  - Fully ignored: no storage change, no count, no error, even if addr is invalid.
- err and err_addr clear only on reset.
- wr_en=0: no state change regardless of addr or data_in.
- Checksum invariant: after every edge, checksum equals the XOR of all current words.
- wr_count wraps never; saturation is required.
- No X propagation: all outputs are defined from reset onward.

Test Plan (DEPTH=4, INIT_BASE=1):
1. Release reset, sweep addr 0,4,8,12 with wr_en=0 -> data_out 1,2,4,8; checksum=0x0000000F; wr_count=0; err=0.
2. wr_en=1, addr=4, data_in=0xA5A50000 for one cycle:
   - data_out=2 during that cycle, 0xA5A50000 after.
   - checksum=0xA5A5000D; wr_count=1.
3. Write addr=6 data 0x1234, then addr=16 data 0x5678:
   - err=1 and err_addr=6 after the first edge.
   - err_addr stays 6 after the second.
   - Memory, checksum (0x0000000F) and wr_count (0) unchanged.
4. lock=1, wr_en=1, addr=0, data_in=0xFFFFFFFF -> mem[0] stays 1; wr_count and checksum unchanged; err stays 0.
5. Pair with the rotate sequencer for its full 200-cycle run -> checksum always equals the XOR of the four words read back; wr_count equals the number of write strobes; err=0.
6. Assert nrst mid-write (wr_en=1, addr=8) -> outputs return immediately to the reset values of scenario 1; no write is committed.

Source files
------------

// File: rtl/word_mem.sv
// Word-organised scratch memory with write counting, running XOR checksum and sticky bad-address capture.
// Reads are combinational (zero latency); writes commit on the clock edge and are never stalled.
module word_mem #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] INIT_BASE = 32'h0000_0001
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        wr_en,
    input  logic        lock,
    input  logic [31:0] addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic [15:0] wr_count,
    output logic [31:0] checksum,
    output logic        err,
    output logic [31:0] err_addr
);
    localparam int AW = $clog2(DEPTH);

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        int s;
        s = n % 32;
        if (s == 0)
            return x;
        return (x << s) | (x >> (32 - s));
    endfunction

    function automatic logic [31:0] reset_sum();
        logic [31:0] acc;
        acc = '0;
        for (int i = 0; i < DEPTH; i++)
            acc = acc ^ rotl(INIT_BASE, i);
        return acc;
    endfunction

    localparam logic [31:0] RESET_SUM = reset_sum();

    logic [31:0]   mem [DEPTH];
    logic          addr_ok;
    logic [AW-1:0] idx;
    logic          wr_ok;
    logic          wr_bad;

    // Valid only when word-aligned and every bit above the index field is zero.
    assign addr_ok = (addr[1:0] == 2'b00) && (addr[31:AW+2] == '0);
    assign idx     = addr[AW+1:2];
    assign wr_ok   = wr_en && !lock && addr_ok;
    assign wr_bad  = wr_en && !lock && !addr_ok;

    assign data_out = addr_ok ? mem[idx] : 32'h0;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= rotl(INIT_BASE, i);
        end else if (wr_ok) begin
            mem[idx] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_count <= '0;
            checksum <= RESET_SUM;
            err      <= 1'b0;
            err_addr <= '0;
        end else begin
            if (wr_ok) begin
                // Old word leaves the checksum, new word enters it.
                checksum <= checksum ^ mem[idx] ^ data_in;
                if (wr_count != 16'hFFFF)
                    wr_count <= wr_count + 16'd1;
            end
            if (wr_bad) begin
                err <= 1'b1;
                if (!err)
                    err_addr <= addr;
            end
        end
    end
endmodule

// File: tb/tb_word_mem.sv
// Randomised and directed checks of word_mem against an array-based reference model.
module tb_word_mem;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        wr_en = 1'b0;
    logic        lock = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] data_in = '0;
    logic [31:0] data_out;
    logic [15:0] wr_count;
    logic [31:0] checksum;
    logic        err;
    logic [31:0] err_addr;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] ref_mem [DEPTH];
    int          ref_count;
    logic        ref_err;
    logic [31:0] ref_err_addr;

    word_mem #(.DEPTH(DEPTH), .INIT_BASE(32'h0000_0001)) dut (
        .clk      (clk),
        .nrst     (nrst),
        .wr_en    (wr_en),
        .lock     (lock),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .wr_count (wr_count),
        .checksum (checksum),
        .err      (err),
        .err_addr (err_addr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit ref_valid(input logic [31:0] a);
        return (a % 4 == 0) && (a / 4 < DEPTH);
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_valid(a) ? ref_mem[a / 4] : 32'h0;
    endfunction

    function automatic logic [31:0] ref_sum();
        logic [31:0] acc;
        acc = '0;
        for (int i = 0; i < DEPTH; i++)
            acc ^= ref_mem[i];
        return acc;
    endfunction

    task automatic ref_reset();
        for (int i = 0; i < DEPTH; i++)
            ref_mem[i] = 32'h1 << i;
        ref_count    = 0;
        ref_err      = 1'b0;
        ref_err_addr = '0;
    endtask

    task automatic ref_edge(input logic we, input logic lk, input logic [31:0] a, input logic [31:0] d);
        if (we && !lk) begin
            if (ref_valid(a)) begin
                ref_mem[a / 4] = d;
                if (ref_count < 65535)
                    ref_count++;
            end else begin
                if (!ref_err)
                    ref_err_addr = a;
                ref_err = 1'b1;
            end
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "_rd"},   data_out, ref_read(addr));
        check({tag, "_cnt"},  {16'h0, wr_count}, ref_count);
        check({tag, "_sum"},  checksum, ref_sum());
        check({tag, "_err"},  {31'h0, err}, {31'h0, ref_err});
        check({tag, "_eadr"}, err_addr, ref_err_addr);
    endtask

    // One cycle: drive at negedge, check the old word before the edge, check all state after it.
    task automatic apply(input string tag, input logic we, input logic lk,
                         input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        wr_en = we; lock = lk; addr = a; data_in = d;
        #1;
        check({tag, "_pre"}, data_out, ref_read(a));
        @(posedge clk);
        ref_edge(we, lk, a, d);
        #1;
        check_state(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        nrst = 1'b0; wr_en = 1'b0; lock = 1'b0;
        ref_reset();
        @(negedge clk);
        nrst = 1'b1;
    endtask

    initial begin
        logic [31:0] a, d, w;
        int   target;
        ref_reset();
        repeat (2) @(posedge clk);
        #1;
        check_state("rst");
        @(negedge clk);
        nrst = 1'b1;

        // Read sweep with no writes.
        for (int i = 0; i < DEPTH; i++)
            apply("sweep", 1'b0, 1'b0, 32'(i * 4), 32'hDEAD_BEEF);
        check("init_sum", checksum, 32'h0000_000F);

        apply("wr4", 1'b1, 1'b0, 32'd4, 32'hA5A5_0000);
        check("wr4_sum_lit", checksum, 32'hA5A5_000D);
        check("wr4_cnt_lit", {16'h0, wr_count}, 32'd1);
        check("wr4_rd_lit", data_out, 32'hA5A5_0000);

        do_reset();
        apply("bad6", 1'b1, 1'b0, 32'd6, 32'h0000_1234);
        check("bad6_eadr_lit", err_addr, 32'd6);
        apply("bad16", 1'b1, 1'b0, 32'd16, 32'h0000_5678);
        check("bad16_eadr_lit", err_addr, 32'd6);
        check("bad16_sum_lit", checksum, 32'h0000_000F);

        do_reset();
        apply("lock0", 1'b1, 1'b1, 32'd0, 32'hFFFF_FFFF);
        apply("lockbad", 1'b1, 1'b1, 32'd3, 32'hFFFF_FFFF);
        apply("lockrd", 1'b0, 1'b0, 32'd0, 32'h0);
        check("lock_rd_lit", data_out, 32'h1);

        // Rotate-and-writeback sequencer: read a word, write it back rotated left by one.
        do_reset();
        for (int c = 0; c < 100; c++) begin
            a = 32'($urandom_range(0, DEPTH - 1) * 4);
            apply("seq_rd", 1'b0, 1'b0, a, 32'h0);
            w = ref_read(a);
            apply("seq_wr", 1'b1, 1'b0, a, {w[30:0], w[31]});
        end
        check("seq_cnt", {16'h0, wr_count}, 32'd100);
        check("seq_err", {31'h0, err}, 32'd0);

        // Unconstrained mix of valid, invalid, locked and idle cycles.
        for (int c = 0; c < 300; c++) begin
            case ($urandom_range(0, 3))
                0, 1, 2: a = 32'($urandom_range(0, DEPTH - 1) * 4);
                default: a = $urandom;
            endcase
            d = $urandom;
            apply("rnd", 1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0), a, d);
        end

        // Drive the write counter into saturation.
        target = 65535 - ref_count;
        @(negedge clk);
        wr_en = 1'b1; lock = 1'b0;
        for (int c = 0; c < target + 5; c++) begin
            a = 32'($urandom_range(0, DEPTH - 1) * 4);
            d = $urandom;
            addr = a; data_in = d;
            @(posedge clk);
            ref_edge(1'b1, 1'b0, a, d);
            @(negedge clk);
        end
        wr_en = 1'b0;
        #1;
        check_state("sat");
        check("sat_lit", {16'h0, wr_count}, 32'h0000_FFFF);
        apply("sat_more", 1'b1, 1'b0, 32'd0, 32'h1357_9BDF);

        // Reset asserted in the middle of a write cycle.
        @(negedge clk);
        wr_en = 1'b1; lock = 1'b0; addr = 32'd8; data_in = 32'hCAFE_F00D;
        #2;
        nrst = 1'b0;
        ref_reset();
        #1;
        check_state("arst");
        check("arst_rd_lit", data_out, 32'h4);
        check("arst_sum_lit", checksum, 32'h0000_000F);
        @(posedge clk);
        #1;
        check_state("arst_hold");
        @(negedge clk);
        wr_en = 1'b0;
        nrst = 1'b1;
        apply("post_rst", 1'b0, 1'b0, 32'd8, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
